// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: Fetch->Decode decoupling queue.
// Holds up to DEPTH {instruction, PC} pairs in a circular buffer so Fetch can run
// ahead while Decode stalls. Decode always sees the oldest entry, or a zero bubble
// when the queue is empty. FlushD empties the queue on the next edge.
module fetch_decode_buffer #(
  parameter int N     = 32,
  parameter int PCW   = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 InstrF,
  input  logic [PCW-1:0]               PCF,
  input  logic                         ValidF,
  output logic                         FullF,
  input  logic                         StallD,
  input  logic                         FlushD,
  output logic [N-1:0]                 InstrD,
  output logic [PCW-1:0]               PCD,
  output logic                         ValidD,
  output logic [$clog2(DEPTH+1)-1:0]   CountD
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [N-1:0]    instrMem [DEPTH];
  logic [PCW-1:0]  pcMem    [DEPTH];
  logic [PTRW-1:0] wrPtr;
  logic [PTRW-1:0] rdPtr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;

  // Status is derived from the registered count only, so FullF has no input path.
  assign FullF  = (count == CNTW'(DEPTH));
  assign ValidD = (count != '0);
  assign CountD = count;

  // A full queue refuses pushes even when the head pops in the same cycle;
  // a flush overrides both push and pop.
  assign push = ValidF & ~FullF & ~FlushD;
  assign pop  = ValidD & ~StallD & ~FlushD;

  // Head read mux: storage contents are only exposed while an entry is valid.
  always_comb begin
    InstrD = '0;
    PCD    = '0;
    if (ValidD) begin
      InstrD = instrMem[rdPtr];
      PCD    = pcMem[rdPtr];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (FlushD) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTRW'(1);
      if (pop)  rdPtr <= rdPtr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so no stale instruction survives it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem[i] <= '0;
        pcMem[i]    <= '0;
      end
    end else if (push) begin
      instrMem[wrPtr] <= InstrF;
      pcMem[wrPtr]    <= PCF;
    end
  end

endmodule
